config_loader: RTL

- Bitstream loader directly upstream of the tile array.
- Accepts a byte-wide configuration stream over a valid/ready handshake and assembles 4-byte frames (tile address plus 22-bit config word).
- Broadcasts each frame as a one-cycle config_en pulse with config_addr/config_data to every pe_tile; each tile latches when config_addr matches its address parameter.
- Detects end-of-bitstream, counts issued frames, and flags malformed frames.

---
 rtl/config_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// Byte-stream configuration loader feeding the tile array.
// Assembles addr + 3 data bytes into frames and broadcasts them.
module config_loader #(
  parameter int         NUM_TILES = 16,
  parameter logic [7:0] END_ADDR  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        config_en,
  output logic [7:0]  config_addr,
  output logic [21:0] config_data,
  output logic        done,
  output logic        err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_D0,
    S_D1,
    S_D2,
    S_CHECK,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [8:0] NT = NUM_TILES[8:0];

  state_t      state;
  logic [7:0]  addr_q;
  logic [15:0] data_q;
  logic [7:0]  d2_q;
  logic        xfer;
  logic        frame_ok;

  assign xfer     = in_valid && in_ready;
  assign frame_ok = ({1'b0, addr_q} < NT) && (d2_q[7:6] == 2'b00);

  // Frame assembly FSM with registered handshake and broadcast outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ADDR;
      in_ready    <= 1'b1;
      config_en   <= 1'b0;
      config_addr <= 8'h00;
      config_data <= 22'h0;
      done        <= 1'b0;
      err         <= 1'b0;
      frame_count <= 16'h0;
      addr_q      <= 8'h00;
      data_q      <= 16'h0;
      d2_q        <= 8'h00;
    end else begin
      config_en <= 1'b0;
      case (state)
        S_ADDR: begin
          if (xfer) begin
            if (in_data == END_ADDR) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              addr_q <= in_data;
              state  <= S_D0;
            end
          end
        end
        S_D0: begin
          if (xfer) begin
            data_q[7:0] <= in_data;
            state       <= S_D1;
          end
        end
        S_D1: begin
          if (xfer) begin
            data_q[15:8] <= in_data;
            state        <= S_D2;
          end
        end
        S_D2: begin
          if (xfer) begin
            d2_q     <= in_data;
            state    <= S_CHECK;
            in_ready <= 1'b0;
          end
        end
        S_CHECK: begin
          if (frame_ok) begin
            state       <= S_ISSUE;
            config_en   <= 1'b1;
            config_addr <= addr_q;
            config_data <= {d2_q[5:0], data_q};
            if (frame_count != 16'hFFFF)
              frame_count <= frame_count + 16'd1;
          end else begin
            err      <= 1'b1;
            state    <= S_ADDR;
            in_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          state    <= S_ADDR;
          in_ready <= 1'b1;
        end
        S_DONE: begin
          state    <= S_DONE;
          in_ready <= 1'b0;
        end
        default: begin
          state    <= S_ADDR;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
